sfp_ctrl: RTL and testbench

Sequencer for a row of `col` SFP accumulate/ReLU lanes sitting between the PE array's output FIFO (OFIFO) and the psum/output SRAM. For each output vector it:
- clears the lanes,
- pops `num_acc` partial-sum vectors from the OFIFO into the lanes,
- writes the ReLU'd lane result to memory at consecutive addresses.

It repeats this for `num_out` vectors per pass, driven by a single `start` pulse.

---
 rtl/sfp_ctrl.sv | 120 ++++++++++++
 tb/tb_sfp_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_ctrl.sv
// Sequencer for a row of SFP accumulate/ReLU lanes: clears the lanes, pops num_acc psum
// vectors from the OFIFO into them, then writes the lane result out, num_out times per pass.
module sfp_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int acc_bw  = 4,
  parameter int addr_bw = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [acc_bw-1:0]      num_acc,
  input  logic [addr_bw-1:0]     num_out,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_data,
  output logic                   ofifo_rd,
  output logic                   sfp_reset,
  output logic                   sfp_acc,
  output logic [col*psum_bw-1:0] sfp_data_in,
  input  logic [col*psum_bw-1:0] sfp_data_out,
  output logic                   mem_wr,
  output logic [addr_bw-1:0]     mem_addr,
  output logic [col*psum_bw-1:0] mem_wdata,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [2:0] {IDLE, CLR, ACC, DRAIN, WB} state_t;

  localparam logic [acc_bw-1:0]  ACC_ONE = acc_bw'(1);
  localparam logic [addr_bw-1:0] OUT_ONE = addr_bw'(1);

  state_t               state_q, state_d;
  logic [acc_bw-1:0]    num_acc_q, num_acc_d, acc_cnt_q, acc_cnt_d;
  logic [addr_bw-1:0]   num_out_q, num_out_d, out_cnt_q, out_cnt_d;
  logic [addr_bw-1:0]   base_q, base_d;
  logic                 done_q, done_d;
  logic                 sfp_acc_q;
  logic [col*psum_bw-1:0] sfp_data_in_q;

  // Gated by reset so a mid-pass reset never consumes a FIFO word or commits a write.
  assign ofifo_rd    = !reset && (state_q == ACC) && ofifo_valid;
  assign mem_wr      = !reset && (state_q == WB);
  assign mem_addr    = base_q + out_cnt_q;
  assign mem_wdata   = sfp_data_out;
  assign sfp_reset   = reset || (state_q == CLR);
  assign sfp_acc     = sfp_acc_q;
  assign sfp_data_in = sfp_data_in_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

  always_comb begin
    state_d   = state_q;
    num_acc_d = num_acc_q;
    num_out_d = num_out_q;
    base_d    = base_q;
    acc_cnt_d = acc_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (num_acc != '0) && (num_out != '0)) begin
          num_acc_d = num_acc;
          num_out_d = num_out;
          base_d    = base_addr;
          acc_cnt_d = '0;
          out_cnt_d = '0;
          state_d   = CLR;
        end
      end
      CLR: state_d = ACC;
      ACC: begin
        if (ofifo_rd) begin
          if (acc_cnt_q == num_acc_q - ACC_ONE) begin
            acc_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            acc_cnt_d = acc_cnt_q + ACC_ONE;
          end
        end
      end
      // last registered addend lands in the lanes during this cycle
      DRAIN: state_d = WB;
      WB: begin
        if (out_cnt_q == num_out_q - OUT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          out_cnt_d = out_cnt_q + OUT_ONE;
          state_d   = CLR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      num_acc_q     <= '0;
      num_out_q     <= '0;
      base_q        <= '0;
      acc_cnt_q     <= '0;
      out_cnt_q     <= '0;
      done_q        <= 1'b0;
      sfp_acc_q     <= 1'b0;
      sfp_data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      num_acc_q <= num_acc_d;
      num_out_q <= num_out_d;
      base_q    <= base_d;
      acc_cnt_q <= acc_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      sfp_acc_q <= ofifo_rd;
      if (ofifo_rd) sfp_data_in_q <= ofifo_data;
    end
  end
endmodule

// File: tb/tb_sfp_ctrl.sv
// Bench for sfp_ctrl: behavioural SFP lanes and OFIFO around the DUT, expected writes
// computed as per-lane ReLU(sum) of the words fed in for each output.
module tb_sfp_ctrl;
  localparam int COL = 8, PB = 16, AB = 4, ADB = 11;
  localparam int W = COL * PB;

  logic           clk = 1'b0;
  logic           reset, start;
  logic [AB-1:0]  num_acc;
  logic [ADB-1:0] num_out, base_addr;
  logic           ofifo_valid;
  logic [W-1:0]   ofifo_data;
  logic           ofifo_rd, sfp_reset, sfp_acc, mem_wr, busy, done;
  logic [W-1:0]   sfp_data_in, sfp_data_out, mem_wdata;
  logic [ADB-1:0] mem_addr;

  always #5 clk = ~clk;

  sfp_ctrl #(.col(COL), .psum_bw(PB), .acc_bw(AB), .addr_bw(ADB)) dut (
    .clk(clk), .reset(reset), .start(start), .num_acc(num_acc), .num_out(num_out),
    .base_addr(base_addr), .ofifo_valid(ofifo_valid), .ofifo_data(ofifo_data),
    .ofifo_rd(ofifo_rd), .sfp_reset(sfp_reset), .sfp_acc(sfp_acc),
    .sfp_data_in(sfp_data_in), .sfp_data_out(sfp_data_out), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  // Lanes: clear on sfp_reset, accumulate on sfp_acc, ReLU on the way out.
  logic [PB-1:0] lane_q [COL];
  always @(posedge clk)
    for (int i = 0; i < COL; i++)
      if (sfp_reset)    lane_q[i] <= '0;
      else if (sfp_acc) lane_q[i] <= lane_q[i] + sfp_data_in[i*PB +: PB];
  always_comb begin
    sfp_data_out = '0;
    for (int i = 0; i < COL; i++)
      sfp_data_out[i*PB +: PB] = lane_q[i][PB-1] ? '0 : lane_q[i];
  end

  int n_assert = 0, n_fail = 0;
  logic [W-1:0]   fifo[$], words[$], exp_data[$];
  logic [ADB-1:0] exp_addr[$];
  logic [W-1:0]   last_wdata;
  int c_pop, c_acc, c_clr, c_wr, c_done, c_bad;
  int vld_mode, pat_i;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    c_pop = 0; c_acc = 0; c_clr = 0; c_wr = 0; c_done = 0; c_bad = 0;
  endtask

  // One clock: drive FIFO head at the negedge, sample 1ns later, move to next negedge.
  task automatic cyc();
    bit v;
    case (vld_mode)
      0:       v = 1'b1;
      1:       v = pat[pat_i % 6];
      default: v = 1'($urandom_range(1, 0));
    endcase
    pat_i++;
    ofifo_valid = v && (fifo.size() != 0);
    ofifo_data  = (fifo.size() != 0) ? fifo[0] : '0;
    #1;
    if (ofifo_rd) begin
      c_pop++;
      if (fifo.size() != 0) void'(fifo.pop_front());
      else c_bad++;
    end
    if (sfp_acc) c_acc++;
    if (sfp_reset) c_clr++;
    if (sfp_acc && (sfp_reset || mem_wr)) c_bad++;
    if (done) begin
      c_done++;
      if (busy) c_bad++;
    end
    if (mem_wr) begin
      c_wr++;
      last_wdata = mem_wdata;
      if (exp_addr.size() == 0) c_bad++;
      else begin
        chk("wr_addr", W'(mem_addr), W'(exp_addr.pop_front()));
        chk("wr_data", mem_wdata, exp_data.pop_front());
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    int t;
    for (int l = 0; l < COL; l++) begin
      t = int'($urandom_range(200, 0)) - 100;
      v[l*PB +: PB] = PB'(t);
    end
    return v;
  endfunction

  // Reference: output o = per-lane ReLU of the sum of words[o*na .. o*na+na-1].
  task automatic build_expect(input int na, input int no, input int base);
    logic [W-1:0] e, wv;
    int s;
    exp_addr.delete(); exp_data.delete();
    for (int o = 0; o < no; o++) begin
      e = '0;
      for (int l = 0; l < COL; l++) begin
        s = 0;
        for (int a = 0; a < na; a++) begin
          wv = words[o*na + a];
          s += int'($signed(wv[l*PB +: PB]));
        end
        e[l*PB +: PB] = (s < 0) ? '0 : PB'(s);
      end
      exp_addr.push_back(ADB'((base + o) % (1 << ADB)));
      exp_data.push_back(e);
    end
  endtask

  task automatic run_pass(input int na, input int no, input int base, input int mode,
                          input bit directed, input int mid_start, input int done_exp);
    int cyc_i, done_at;
    if (!directed) begin
      words.delete();
      for (int k = 0; k < na*no; k++) words.push_back(rand_vec());
    end
    fifo = words;
    build_expect(na, no, base);
    clear_counts();
    vld_mode = mode;
    start = 1'b1; num_acc = AB'(na); num_out = ADB'(no); base_addr = ADB'(base);
    cyc();
    start = 1'b0;
    num_acc = AB'($urandom); num_out = ADB'($urandom); base_addr = ADB'($urandom);
    pat_i = 5;
    cyc_i = 1; done_at = -1;
    while (c_done == 0 && cyc_i < 3000) begin
      if (cyc_i == mid_start) begin
        start = 1'b1; num_acc = AB'(na); num_out = ADB'(no + 2);
      end
      cyc();
      start = 1'b0;
      if (c_done != 0) done_at = cyc_i;
      cyc_i++;
    end
    chk("done_seen", W'(c_done != 0), W'(1));
    if (done_exp > 0) chk("done_cycle", W'(done_at), W'(done_exp));
    repeat (5) cyc();
    chk("pops", W'(c_pop), W'(na*no));
    chk("acc_cycles", W'(c_acc), W'(na*no));
    chk("writes", W'(c_wr), W'(no));
    chk("clr_pulses", W'(c_clr), W'(no));
    chk("done_count", W'(c_done), W'(1));
    chk("protocol", W'(c_bad), W'(0));
    chk("idle_busy", W'(busy), W'(0));
  endtask

  initial begin
    logic [W-1:0] v, exp7;
    reset = 1'b1; start = 1'b1; num_acc = 4'd3; num_out = 11'd1; base_addr = 11'h55;
    ofifo_valid = 1'b1; ofifo_data = '1;
    vld_mode = 0; pat_i = 0; last_wdata = '0;

    // Reset values, with start and valid held high
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); #1;
      chk("rst_rd", W'(ofifo_rd), W'(0));
      chk("rst_acc", W'(sfp_acc), W'(0));
      chk("rst_din", sfp_data_in, '0);
      chk("rst_wr", W'(mem_wr), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_addr", W'(mem_addr), W'(0));
      chk("rst_sfpreset", W'(sfp_reset), W'(1));
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (2) cyc();

    // Single output: lane0 5,-2,4 -> 7; lane1 -1 x3 -> 0
    words.delete();
    v = '0; v[15:0] = 16'd5;      v[31:16] = 16'hFFFF; words.push_back(v);
    v = '0; v[15:0] = 16'hFFFE;   v[31:16] = 16'hFFFF; words.push_back(v);
    v = '0; v[15:0] = 16'd4;      v[31:16] = 16'hFFFF; words.push_back(v);
    exp7 = W'(7);
    run_pass(3, 1, 'h010, 0, 1'b1, 0, 7);
    chk("s2_data", last_wdata, exp7);

    // Same words through a stalling FIFO
    last_wdata = '0;
    run_pass(3, 1, 'h010, 1, 1'b1, 0, 0);
    chk("s3_data", last_wdata, exp7);

    // Address wrap
    run_pass(2, 4, 'h7FE, 0, 1'b0, 0, 21);

    // Start with num_acc=0 is ignored
    clear_counts(); fifo.delete(); exp_addr.delete(); exp_data.delete();
    start = 1'b1; num_acc = '0; num_out = 11'd3; base_addr = 11'h20;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    chk("zero_acc_busy", W'(busy), W'(0));
    chk("zero_acc_done", W'(c_done), W'(0));
    chk("zero_acc_wr", W'(c_wr), W'(0));

    // Start mid-pass with a different count is ignored
    run_pass(2, 3, 'h100, 0, 1'b0, 4, 16);

    // Reset during ACC of output 2 of 4
    words.delete();
    for (int k = 0; k < 12; k++) words.push_back(rand_vec());
    fifo = words;
    build_expect(3, 4, 'h200);
    void'(exp_addr.pop_back()); void'(exp_addr.pop_back()); void'(exp_addr.pop_back());
    void'(exp_data.pop_back()); void'(exp_data.pop_back()); void'(exp_data.pop_back());
    clear_counts(); vld_mode = 0;
    start = 1'b1; num_acc = 4'd3; num_out = 11'd4; base_addr = 11'h200;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 200 && c_wr == 0; i++) cyc();
    chk("mid_first_wr", W'(c_wr), W'(1));
    cyc(); cyc();
    reset = 1'b1; ofifo_valid = 1'b1;
    #1;
    chk("mid_rst_rd", W'(ofifo_rd), W'(0));
    chk("mid_rst_wr", W'(mem_wr), W'(0));
    chk("mid_rst_sfpreset", W'(sfp_reset), W'(1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_busy", W'(busy), W'(0));
    chk("mid_acc", W'(sfp_acc), W'(0));
    chk("mid_done", W'(done), W'(0));
    chk("mid_addr", W'(mem_addr), W'(0));
    @(negedge clk);
    fifo.delete(); exp_addr.delete(); exp_data.delete(); clear_counts();
    repeat (20) cyc();
    chk("mid_no_wr", W'(c_wr), W'(0));
    chk("mid_no_done", W'(c_done), W'(0));
    run_pass(1, 1, 'h300, 0, 1'b0, 0, 5);

    // Randomised passes with random FIFO stalls
    for (int p = 0; p < 6; p++)
      run_pass(int'($urandom_range(15, 1)), int'($urandom_range(5, 1)),
               int'($urandom_range(2047, 0)), 2, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
